if_fetch_unit: RTL

- Instruction-fetch producer that drives the sel/ins pair into the IF/ID pipeline buffer.
- Owns the PC and issues word-aligned requests to instruction memory over a req/gnt/rvalid handshake.
- Holds returned instructions in a small in-order queue and presents them to the IF/ID buffer.
- Honours downstream stall; on redirect (taken branch/jump) it flushes in-flight and queued instructions.

---
 rtl/if_fetch_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches words over req/gnt/rvalid and queues the
// returned instructions, in order, for the IF/ID buffer (sel/ins/pc_o).
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        sel,
   output logic [31:0] ins,
   output logic [31:0] pc_o
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = CW + 2;
   logic [31:0]   pc_q, pc_d, rpc_q, rpc_d, last_q, last_d;
   logic [CW-1:0] outst_q, outst_d, disc_q, disc_d, cnt_q, cnt_d;
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [31:0]   instr_q [DEPTH], instr_d [DEPTH], qpc_q [DEPTH], qpc_d [DEPTH];
   logic [SW-1:0] used;
   logic          fire, drop, push, pop;
   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   // rpc tracks the PC of the next non-discarded response: after a redirect all
   // surviving responses belong to the sequential stream starting at the target.
   always_comb begin
      used      = SW'(cnt_q) + SW'(outst_q) + SW'(disc_q);
      imem_req  = rst_n && !redirect && (used < SW'(DEPTH));
      imem_addr = pc_q;
      sel       = cnt_q != '0;
      ins       = sel ? instr_q[rd_q] : '0;
      pc_o      = sel ? qpc_q[rd_q] : last_q;
      fire      = imem_req && imem_gnt;
      drop      = imem_rvalid && disc_q != '0;
      push      = imem_rvalid && disc_q == '0 && !redirect;
      pop       = sel && !stall && !redirect;
      last_d    = pc_o;
      instr_d   = instr_q;
      qpc_d     = qpc_q;
      pc_d      = fire ? pc_q + 32'd4 : pc_q;
      rpc_d     = push ? rpc_q + 32'd4 : rpc_q;
      outst_d   = outst_q + CW'(fire) - CW'(push);
      disc_d    = disc_q - CW'(drop);
      cnt_d     = cnt_q + CW'(push) - CW'(pop);
      rd_d      = pop ? inc(rd_q) : rd_q;
      wr_d      = push ? inc(wr_q) : wr_q;
      if (push) begin
         instr_d[wr_q] = imem_rdata;
         qpc_d[wr_q]   = rpc_q;
      end
      if (redirect) begin
         pc_d    = redirect_pc & ~32'h3;
         rpc_d   = pc_d;
         outst_d = '0;
         disc_d  = disc_q + outst_q - CW'(imem_rvalid);
         cnt_d   = '0;
         rd_d    = '0;
         wr_d    = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         rpc_q   <= RESET_PC;
         last_q  <= RESET_PC;
         outst_q <= '0;
         disc_q  <= '0;
         cnt_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            qpc_q[i]   <= '0;
         end
      end else begin
         pc_q    <= pc_d;
         rpc_q   <= rpc_d;
         last_q  <= last_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         instr_q <= instr_d;
         qpc_q   <= qpc_d;
      end
   end
endmodule
